// File: rtl/ysyx_pipe_pkg.sv
// ysyx_pipe_pkg
// Shared definitions for the pipeline handoff queues, the ROB and the
// reservation stations.
//   ROB_SIZE : number of ROB entries (from `YSYX_ROB_SIZE, default 16)
//   TAG_W    : ROB tag width; the MSB is the wrap bit
//   tag_t    : ROB tag type
//   younger  : age comparison between two in-flight tags

`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

package ysyx_pipe_pkg;

    localparam int unsigned ROB_SIZE = `YSYX_ROB_SIZE;
    localparam int unsigned TAG_W    = $clog2(ROB_SIZE) + 1;

    typedef logic [TAG_W-1:0] tag_t;

    // a is younger than b. The index compare is inverted when the two tags
    // sit on different laps of the ROB (wrap bits differ).
    function automatic logic younger(tag_t a, tag_t b);
        return (a[TAG_W-2:0] > b[TAG_W-2:0]) ^ (a[TAG_W-1] != b[TAG_W-1]);
    endfunction

endpackage

// File: rtl/ysyx_pipe_queue_kill_scan.sv
// ysyx_kill_scan
// Combinational scan used by a selective kill. Walks the live entries of the
// queue in program order starting at head and returns how many leading
// entries are not younger than kill_tag. Because tags enter in program order
// the killed entries are always a contiguous suffix, so the first younger
// entry ends the surviving run.
// Ports:
//   tags     : per-slot stored tags (indexed by physical slot)
//   head     : physical slot of the oldest entry
//   count    : number of live entries
//   kill_tag : entries strictly younger than this tag are discarded
//   keep_len : number of surviving entries counted from head

module ysyx_kill_scan #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = ysyx_pipe_pkg::TAG_W
) (
    input  logic [TAG_W-1:0]             tags [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [TAG_W-1:0]             kill_tag,
    output logic [$clog2(DEPTH+1)-1:0]   keep_len
);
    import ysyx_pipe_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic run;
    ptr_t idx;

    always_comb begin
        keep_len = '0;
        run      = 1'b1;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Pointer arithmetic wraps naturally at DEPTH (power of two).
            idx = head + ptr_t'(i);
            if (run && (cnt_t'(i) < count) && !younger(tag_t'(tags[idx]), tag_t'(kill_tag))) begin
                keep_len = keep_len + cnt_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ysyx_pipe_queue.sv
// ysyx_pipe_queue
// Tag-aware in-order pipeline buffer between pipeline stages (IDU->EXU,
// EXU->ROB). Holds up to DEPTH entries of an opaque payload plus its ROB tag.
// Supports a full flush and a selective kill of every entry younger than a
// mispredicted ROB tag.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   in_valid/in_ready     : producer handshake; in_ready depends on state only
//   in_data, in_tag       : incoming payload and its ROB tag
//   out_valid/out_ready   : consumer handshake for the head entry
//   out_data, out_tag     : head payload and tag (don't-care when !out_valid)
//   flush                 : discard everything (highest priority)
//   kill_valid, kill_tag  : discard entries strictly younger than kill_tag
//   count                 : current occupancy
// An entry pushed in cycle N is visible at the output no earlier than N+1.

module ysyx_pipe_queue #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = ysyx_pipe_pkg::TAG_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    input  logic                       flush,
    input  logic                       kill_valid,
    input  logic [TAG_W-1:0]           kill_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import ysyx_pipe_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    // Storage
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];

    // Pointers and occupancy; count is kept separately so full/empty are
    // unambiguous with naturally wrapping pointers.
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    cnt_t count_q, count_d;

    // Datapath control
    logic head_killed;
    logic in_killed;
    logic push_fire;
    logic push_store;
    logic pop_fire;
    cnt_t scan_len;
    cnt_t keep_len;
    ptr_t tail_base;
    logic wr_en;

    ysyx_kill_scan #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_kill_scan (
        .tags     (tag_q),
        .head     (head_q),
        .count    (count_q),
        .kill_tag (kill_tag),
        .keep_len (scan_len)
    );

    // Handshake outputs
    assign in_ready    = (count_q != FULL_CNT);
    assign head_killed = kill_valid && younger(tag_t'(tag_q[head_q]), tag_t'(kill_tag));
    assign out_valid   = (count_q != '0) && !flush && !head_killed;
    assign out_data    = data_q[head_q];
    assign out_tag     = tag_q[head_q];
    assign count       = count_q;

    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;

    // An incoming entry younger than the kill point is accepted on the
    // handshake but never written.
    assign in_killed  = kill_valid && younger(tag_t'(in_tag), tag_t'(kill_tag));
    assign push_store = push_fire && !flush && !in_killed;
    assign wr_en      = push_store;

    // Surviving run counted from the current head. A pop in the same cycle
    // only removes the head, which is never part of a killed suffix when it
    // is poppable, so the pop and the kill compose as "pop first, then kill".
    assign keep_len  = kill_valid ? scan_len : count_q;
    assign tail_base = kill_valid ? (head_q + ptr_t'(scan_len)) : tail_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Collapse onto the current head; no pointer reset needed.
            tail_d  = head_q;
            count_d = '0;
        end else begin
            if (pop_fire) begin
                head_d = head_q + ptr_t'(1);
            end
            tail_d  = tail_base + ptr_t'(push_store);
            count_d = keep_len - cnt_t'(pop_fire) + cnt_t'(push_store);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone defines liveness.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[tail_base] <= in_data;
            tag_q[tail_base]  <= in_tag;
        end
    end

`ifndef SYNTHESIS
    logic [TAG_W-1:0] prev_tag;
    assign prev_tag = tag_q[tail_base - ptr_t'(1)];

    a_no_push_when_full : assert property (
        @(posedge clock) disable iff (reset) !in_ready |-> !wr_en
    );

    a_tag_order : assert property (
        @(posedge clock) disable iff (reset)
        (wr_en && (keep_len != '0)) |-> younger(tag_t'(in_tag), tag_t'(prev_tag))
    );

    a_count_bound : assert property (
        @(posedge clock) disable iff (reset) count_q <= FULL_CNT
    );
`endif

endmodule

// File: tb/tb_ysyx_pipe_queue.sv
module tb_ysyx_pipe_queue;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              flush = 1'b0;
    logic              kill_valid = 1'b0;
    logic [TAG_W-1:0]  kill_tag = '0;
    logic [2:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model contents, oldest first
    logic [TAG_W-1:0]  mq_tag [$];
    logic [DATA_W-1:0] mq_data [$];

    ysyx_pipe_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .flush      (flush),
        .kill_valid (kill_valid),
        .kill_tag   (kill_tag),
        .count      (count)
    );

    always #5 clock = ~clock;

    // a is younger than b when it lies 1..16 steps ahead of b around the
    // 32-value tag circle.
    function automatic bit tb_younger(logic [TAG_W-1:0] a, logic [TAG_W-1:0] b);
        logic [TAG_W-1:0] d;
        d = a - b;
        return (d != 0) && (d <= 16);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        kill_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        // Reset in the middle of operation drops contents
        push_one(5'd1, 128'h11);
        push_one(5'd2, 128'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_fill_drain();
        logic [DATA_W-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(TAG_W'(i + 1), DATA_W'(8'hA1 + i));
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_d = DATA_W'(8'hA1 + i);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_tag !== TAG_W'(i + 1)) begin n_fail++; $display("FAIL drain_tag[%0d]: got %0d want %0d", i, out_tag, i + 1); end
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, out_data, exp_d); end
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_wrap_kill();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(TAG_W'(14 + i), DATA_W'(16'hC000 + 14 + i));
        kill_valid = 1'b1;
        kill_tag   = 5'd15;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrapkill_head_valid: got %b want 1", out_valid); end
        tick();
        kill_valid = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL wrapkill_count: got %0d want 2", count); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_tag !== 5'd14) begin n_fail++; $display("FAIL wrapkill_pop0: got %0d want 14", out_tag); end
        tick();
        n_checks++; if (out_tag !== 5'd15 || out_valid !== 1'b1) begin n_fail++; $display("FAIL wrapkill_pop1: got %0d/%b want 15/1", out_tag, out_valid); end
        n_checks++; if (out_data !== DATA_W'(16'hC00F)) begin n_fail++; $display("FAIL wrapkill_data1: got %h want c00f", out_data); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wrapkill_empty: got %0d want 0", count); end
    endtask

    task automatic test_push_kill();
        do_reset();
        push_one(5'd3, 128'h33);
        push_one(5'd4, 128'h44);
        in_valid   = 1'b1;
        in_tag     = 5'd6;
        in_data    = 128'h66;
        kill_valid = 1'b1;
        kill_tag   = 5'd5;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pushkill_in_ready: got %b want 1", in_ready); end
        tick();
        idle();
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL pushkill_count: got %0d want 2", count); end
        kill_valid = 1'b1;
        kill_tag   = 5'd2;
        out_ready  = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL killall_out_valid: got %b want 0", out_valid); end
        tick();
        idle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL killall_count: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        do_reset();
        push_one(5'd7, 128'h77);
        push_one(5'd8, 128'h88);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 5'd9;
        in_data   = 128'h99;
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        idle();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        push_one(5'd10, 128'hAA);
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_tag !== 5'd10 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_tag: got %0d/%b want 10/1", out_tag, out_valid); end
        tick();
        idle();
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(TAG_W'(i + 1), DATA_W'(8'hB1 + i));
        in_valid  = 1'b1;
        in_tag    = 5'd5;
        in_data   = 128'hB5;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_tag !== 5'd1) begin n_fail++; $display("FAIL full_head: got %0d want 1", out_tag); end
        tick();
        idle();
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_freed_ready: got %b want 1", in_ready); end
        push_one(5'd5, 128'hB5);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_repush_count: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (out_tag !== TAG_W'(i + 2) || out_data !== DATA_W'(8'hB2 + i)) begin
                n_fail++; $display("FAIL full_drain[%0d]: got %0d/%h want %0d/%h", i, out_tag, out_data, i + 2, 8'hB2 + i);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        logic [TAG_W-1:0] next_tag;
        bit exp_ready, exp_valid, push_fire, pop;
        int k;
        do_reset();
        mq_tag.delete();
        mq_data.delete();
        next_tag = 5'd20;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            kill_valid = ($urandom_range(0, 7) == 0);
            in_tag     = next_tag;
            in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (mq_tag.size() != 0) begin
                k = $urandom_range(0, mq_tag.size() - 1);
                kill_tag = mq_tag[k] - TAG_W'($urandom_range(0, 1));
            end else begin
                kill_tag = next_tag - 5'd1;
            end
            #1;
            exp_ready = (mq_tag.size() < DEPTH);
            exp_valid = (mq_tag.size() != 0) && !flush &&
                        !(kill_valid && tb_younger(mq_tag[0], kill_tag));
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready); end
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d: got %b want %b", cyc, out_valid, exp_valid); end
            n_checks++; if (count !== 3'(mq_tag.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, count, mq_tag.size()); end
            if (exp_valid) begin
                n_checks++; if (out_tag !== mq_tag[0] || out_data !== mq_data[0]) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d: got %0d/%h want %0d/%h", cyc, out_tag, out_data, mq_tag[0], mq_data[0]);
                end
            end
            if (flush) begin
                mq_tag.delete();
                mq_data.delete();
            end else begin
                push_fire = in_valid && exp_ready;
                pop       = exp_valid && out_ready;
                if (pop) begin
                    void'(mq_tag.pop_front());
                    void'(mq_data.pop_front());
                end
                if (kill_valid) begin
                    while (mq_tag.size() != 0 && tb_younger(mq_tag[$], kill_tag)) begin
                        void'(mq_tag.pop_back());
                        void'(mq_data.pop_back());
                    end
                end
                if (push_fire && !(kill_valid && tb_younger(in_tag, kill_tag))) begin
                    mq_tag.push_back(in_tag);
                    mq_data.push_back(in_data);
                end
            end
            // Keep issued tags contiguous after the youngest survivor
            if (mq_tag.size() != 0) next_tag = mq_tag[$] + 5'd1;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap_kill();
        test_push_kill();
        test_flush();
        test_full_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
